multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle main control FSM for the 16-bit CPU; sequences fetch/decode/execute/mem/writeback.
//  Drives ALUOp into ALUControl plus mux selects and write enables for PC, IR, regfile, memory.
//  One instruction at a time, no pipelining.
// PARAMETERS
//  PC_STEP   2   value selected by ALUSrcB=01 (byte-addressed 16-bit words); informational only
//  STATE_W   4   state register width
// PORTS
//  Clock      in   1  system clock, rising edge
//  Reset      in   1  synchronous, active-high; overrides everything
//  Opcode     in   4  IR[15:12], valid from DECODE onward (IR held by IRWrite=0)
//  Zero       in   1  ALU zero flag, sampled only in BRANCH
//  MemReady   in   1  memory handshake; used only with CPU_MEM_WAIT_EN
//  PCWriteEn  out  1  PC load (unconditional or resolved branch)
//  IorD       out  1  0=PC addresses memory, 1=ALUOut
//  MemRead    out  1  memory read strobe
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  load instruction register
//  RegDst     out  1  0=rt, 1=rd destination
//  MemToReg   out  1  0=ALUOut, 1=MDR to regfile
//  RegWrite   out  1  regfile write enable
//  ALUSrcA    out  1  0=PC, 1=regA
//  ALUSrcB    out  2  00=regB 01=PC_STEP 10=sign-ext imm 11=imm<<1
//  ALUOp      out  2  00 add(lw/sw/PC), 01 sub(beq/bne), 10 R-format, 11 I-format
//  PCSrc      out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
//  Retire     out  1  1-cycle pulse in final state of each legal instruction
//  Illegal    out  1  1-cycle pulse in DECODE on undefined opcode
// BEHAVIOUR
//  Opcodes: 0000/0001/0010 R; 0100 LW; 0101 SW; 0110 BEQ; 0111 BNE; 1000 J;
//   1001 ADDI; 1010 SUBI; 1011 SLTI; all others illegal.
//  Moore outputs from state; only PCWriteEn in BRANCH depends on Zero/Opcode.
//  Unlisted outputs are 0 in every state (ALUOp/ALUSrcB/PCSrc default 00).
//  States / actions / next:
//   FETCH  : MemRead,IRWrite,ALUSrcB=01,ALUOp=00,PCWriteEn,PCSrc=00 -> DECODE
//   DECODE : ALUSrcB=11,ALUOp=00 (precompute branch target) -> by class:
//            R->REXEC, LW/SW->MADDR, BEQ/BNE->BRANCH, J->JUMP, I->IEXEC, illegal->FETCH
//   MADDR  : ALUSrcA=1,ALUSrcB=10,ALUOp=00 -> LW:MRD, SW:MWR
//   MRD    : MemRead,IorD -> MWB
//   MWB    : RegWrite,MemToReg,RegDst=0,Retire -> FETCH
//   MWR    : MemWrite,IorD,Retire -> FETCH
//   REXEC  : ALUSrcA=1,ALUSrcB=00,ALUOp=10 -> RWB
//   RWB    : RegWrite,RegDst=1,MemToReg=0,Retire -> FETCH
//   IEXEC  : ALUSrcA=1,ALUSrcB=10,ALUOp=11 -> IWB
//   IWB    : RegWrite,RegDst=0,MemToReg=0,Retire -> FETCH
//   BRANCH : ALUSrcA=1,ALUSrcB=00,ALUOp=01,PCSrc=01,Retire;
//            PCWriteEn = BEQ ? Zero : ~Zero -> FETCH
//   JUMP   : PCSrc=10,PCWriteEn,Retire -> FETCH
//  Latency (no waits): J/BEQ/BNE 3 cycles, R/I/SW 4, LW 5; Retire marks last cycle.
//  Reset: state<=FETCH on the edge Reset is sampled high; while Reset is high, all
//   write enables/strobes, Retire, Illegal forced 0; first FETCH is the cycle after release.
//  Reset mid-instruction: abandoned at once, no partial write issued afterward.
//  Unused state encodings -> FETCH next cycle, all outputs 0.
//  Illegal: pulse in DECODE, no writes; PC already advanced in FETCH, so it is skipped.
// CONFIGURATION
//  CPU_MEM_WAIT_EN defined: FETCH, MRD, MWR hold while MemReady=0.
//   While held, MemRead/MemWrite/IorD stay asserted; PCWriteEn/IRWrite/Retire qualified by MemReady.
//   PCWriteEn/IRWrite fire exactly once, on the MemReady=1 cycle.
//  Undefined: MemReady ignored; every memory access completes in one cycle.
// TESTING
//  Reset held 3 cycles mid-LW -> outputs 0 during reset; FETCH (MemRead=1,IRWrite=1) cycle after release.
//  Opcode 0001 (ADD) -> FETCH,DECODE,REXEC(ALUOp=10),RWB(RegWrite=1,RegDst=1,Retire=1); 4 cycles.
//  Opcode 0100 (LW) -> MRD has IorD=1,MemRead=1; MWB has MemToReg=1,RegWrite=1; Retire at cycle 5.
//  BEQ Zero=1 -> PCWriteEn=1,PCSrc=01 in BRANCH; BEQ Zero=0 -> PCWriteEn=0; BNE the inverse.
//  Opcode 1111 -> Illegal=1 in DECODE, no RegWrite/MemWrite, FETCH next cycle.
//  CPU_MEM_WAIT_EN, MemReady=0 for 2 cycles in FETCH -> FETCH held 3 cycles, IRWrite/PCWriteEn once.

Source files
------------

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Control bundle between the multi-cycle main control FSM and the 16-bit
// datapath.
//   Datapath -> control : Opcode (IR[15:12]), Zero (ALU flag), MemReady
//   Control -> datapath : PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
//                         MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
//                         Retire, Illegal
// The controller connects through modport master and the datapath through
// modport slave.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWriteEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       Retire;
    logic       Illegal;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Retire, Illegal
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWriteEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Retire, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the non-pipelined 16-bit CPU. Sequences
// FETCH / DECODE / execute / memory / writeback one instruction at a time and
// drives the datapath mux selects, write enables and the ALUOp code.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - synchronous, active-high; forces FETCH and silences every output
//   bus    - multicycle_control_if.master (Opcode/Zero/MemReady in, controls out)
// Parameters:
//   PC_STEP - PC increment the datapath applies for ALUSrcB=01 (reference only)
//   STATE_W - state register width
// Build option:
//   CPU_MEM_WAIT_EN - when defined, FETCH, MRD and MWR stall while MemReady=0;
//                     when undefined MemReady is ignored.
// Outputs are Moore decodes of the state register; only PCWriteEn in BRANCH
// looks at Zero/Opcode and Illegal in DECODE looks at Opcode.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int PC_STEP = 2,
    parameter int STATE_W = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_R   = 3'd0,
        C_LW  = 3'd1,
        C_SW  = 3'd2,
        C_BR  = 3'd3,
        C_J   = 3'd4,
        C_I   = 3'd5,
        C_ILL = 3'd6
    } op_class_t;

    // Opcode to instruction class.
    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t c;
        case (op)
            4'b0000, 4'b0001, 4'b0010: c = C_R;
            4'b0100:                   c = C_LW;
            4'b0101:                   c = C_SW;
            4'b0110, 4'b0111:          c = C_BR;
            4'b1000:                   c = C_J;
            4'b1001, 4'b1010, 4'b1011: c = C_I;
            default:                   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t    state_q;
    state_t    state_d;
    op_class_t op_class_s;
    logic      mem_ready_s;

    // PC_STEP only documents the datapath constant behind ALUSrcB=01.
    logic [STATE_W-1:0] unused_pc_step_s;
    assign unused_pc_step_s = STATE_W'(PC_STEP);

`ifdef CPU_MEM_WAIT_EN
    assign mem_ready_s = bus.MemReady;
`else
    // Memory always answers in one cycle; the handshake input is ignored.
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = bus.MemReady;
    assign mem_ready_s        = 1'b1;
`endif

    assign op_class_s = classify(bus.Opcode);

    logic       pc_write_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_src_s;
    logic       retire_s;
    logic       illegal_s;

    // State register; Reset returns to FETCH on the edge it is sampled high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and raw Moore output decode.
    always_comb begin
        state_d      = S_FETCH;
        pc_write_s   = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        pc_src_s     = 2'b00;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Read stays up while stalled; IR/PC load only on the ready cycle
                // so each fires exactly once per fetch.
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready_s;
                pc_write_s  = mem_ready_s;
                if (mem_ready_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC + (imm<<1) so BRANCH can use ALUOut.
                alu_src_b_s = 2'b11;
                case (op_class_s)
                    C_R:     state_d = S_REXEC;
                    C_LW:    state_d = S_MADDR;
                    C_SW:    state_d = S_MADDR;
                    C_BR:    state_d = S_BRANCH;
                    C_J:     state_d = S_JUMP;
                    C_I:     state_d = S_IEXEC;
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (op_class_s == C_LW) begin
                    state_d = S_MRD;
                end else begin
                    state_d = S_MWR;
                end
            end
            S_MRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
                if (mem_ready_s) begin
                    state_d = S_MWB;
                end else begin
                    state_d = S_MRD;
                end
            end
            S_MWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MWR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
                retire_s    = mem_ready_s;
                if (mem_ready_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MWR;
                end
            end
            S_REXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
                state_d     = S_RWB;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                alu_op_s    = 2'b11;
                state_d     = S_IWB;
            end
            S_IWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                // BEQ takes the branch on Zero, BNE on not-Zero.
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b01;
                pc_src_s    = 2'b01;
                retire_s    = 1'b1;
                if (bus.Opcode == 4'b0110) begin
                    pc_write_s = bus.Zero;
                end else begin
                    pc_write_s = ~bus.Zero;
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_src_s   = 2'b10;
                pc_write_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused encodings: outputs stay at defaults, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset overrides every output while it is high.
    always_comb begin
        if (Reset) begin
            bus.PCWriteEn = 1'b0;
            bus.IorD      = 1'b0;
            bus.MemRead   = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegDst    = 1'b0;
            bus.MemToReg  = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.ALUSrcA   = 1'b0;
            bus.ALUSrcB   = 2'b00;
            bus.ALUOp     = 2'b00;
            bus.PCSrc     = 2'b00;
            bus.Retire    = 1'b0;
            bus.Illegal   = 1'b0;
        end else begin
            bus.PCWriteEn = pc_write_s;
            bus.IorD      = iord_s;
            bus.MemRead   = mem_read_s;
            bus.MemWrite  = mem_write_s;
            bus.IRWrite   = ir_write_s;
            bus.RegDst    = reg_dst_s;
            bus.MemToReg  = mem_to_reg_s;
            bus.RegWrite  = reg_write_s;
            bus.ALUSrcA   = alu_src_a_s;
            bus.ALUSrcB   = alu_src_b_s;
            bus.ALUOp     = alu_op_s;
            bus.PCSrc     = pc_src_s;
            bus.Retire    = retire_s;
            bus.Illegal   = illegal_s;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control: a table of instructions with
// their expected latency, randomized instruction streams, and hand sequences
// for reset mid-instruction and (with CPU_MEM_WAIT_EN) memory stalls.
// Expected outputs come from a per-instruction-class cycle model.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.PC_STEP(2), .STATE_W(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       retire;
        logic       illegal;
    } out_t;

    out_t act;
    assign act = {bus.PCWriteEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                  bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSrc, bus.Retire, bus.Illegal};

    typedef struct {
        logic [3:0] op;
        logic       zero;
        int         lat;
    } vec_t;

    // Cycles per instruction from FETCH through its last state.
    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'b0110, 4'b0111, 4'b1000:                   return 3;
            4'b0000, 4'b0001, 4'b0010, 4'b0101,
            4'b1001, 4'b1010, 4'b1011:                   return 4;
            4'b0100:                                     return 5;
            default:                                     return 2;
        endcase
    endfunction

    function automatic out_t fetch_exp();
        out_t e = '0;
        e.mrd = 1'b1; e.irw = 1'b1; e.srcb = 2'b01; e.pcw = 1'b1;
        return e;
    endfunction

    // Expected outputs in cycle c (0 = FETCH) of instruction op with flag z.
    function automatic out_t model(input logic [3:0] op, input logic z, input int c);
        out_t e = '0;
        bit is_r  = (op <= 4'b0010);
        bit is_i  = (op >= 4'b1001) && (op <= 4'b1011);
        bit is_br = (op == 4'b0110) || (op == 4'b0111);
        if (c == 0) begin
            e = fetch_exp();
        end else if (c == 1) begin
            e.srcb = 2'b11;
            e.illegal = (lat_of(op) == 2);
        end else if (c == 2) begin
            if (op == 4'b0100 || op == 4'b0101) begin
                e.srca = 1'b1; e.srcb = 2'b10;
            end else if (is_r) begin
                e.srca = 1'b1; e.aluop = 2'b10;
            end else if (is_i) begin
                e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 2'b11;
            end else if (is_br) begin
                e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.retire = 1'b1;
                e.pcw = (op == 4'b0110) ? z : ~z;
            end else begin
                e.pcsrc = 2'b10; e.pcw = 1'b1; e.retire = 1'b1;
            end
        end else if (c == 3) begin
            if (op == 4'b0100) begin
                e.mrd = 1'b1; e.iord = 1'b1;
            end else if (op == 4'b0101) begin
                e.mwr = 1'b1; e.iord = 1'b1; e.retire = 1'b1;
            end else begin
                e.rw = 1'b1; e.regdst = is_r; e.retire = 1'b1;
            end
        end else begin
            e.rw = 1'b1; e.m2r = 1'b1; e.retire = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Runs one instruction from FETCH, checking every cycle; returns in FETCH.
    task automatic run_instr(input logic [3:0] op, input logic z, input int lat,
                             input bit rand_ready);
        bus.Opcode = op;
        bus.Zero   = z;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk($sformatf("op%b z%0d cyc%0d", op, z, c), act, model(op, z, c));
            @(posedge clk);
            #1;
`ifndef CPU_MEM_WAIT_EN
            if (rand_ready) bus.MemReady = 1'($urandom_range(0, 1));
`endif
        end
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 4};
        vecs[1]  = '{4'b0001, 1'b1, 4};
        vecs[2]  = '{4'b0010, 1'b0, 4};
        vecs[3]  = '{4'b0100, 1'b0, 5};
        vecs[4]  = '{4'b0101, 1'b1, 4};
        vecs[5]  = '{4'b0110, 1'b1, 3};
        vecs[6]  = '{4'b0110, 1'b0, 3};
        vecs[7]  = '{4'b0111, 1'b1, 3};
        vecs[8]  = '{4'b0111, 1'b0, 3};
        vecs[9]  = '{4'b1000, 1'b0, 3};
        vecs[10] = '{4'b1001, 1'b0, 4};
        vecs[11] = '{4'b1010, 1'b1, 4};
        vecs[12] = '{4'b1011, 1'b0, 4};
        vecs[13] = '{4'b1111, 1'b0, 2};
        vecs[14] = '{4'b0011, 1'b1, 2};
        vecs[15] = '{4'b1100, 1'b0, 2};

        bus.Opcode   = 4'b0000;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        // Power-up reset: every output silent.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_init", act, out_t'(0));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].zero, vecs[i].lat, 1'b0);

        // Reset held 3 cycles in the middle of an LW.
        bus.Opcode = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lw_pre_reset", act, model(4'b0100, 1'b0, c));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_mid_lw", act, out_t'(0));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        run_instr(4'b0100, 1'b0, 5, 1'b0);

`ifdef CPU_MEM_WAIT_EN
        begin
            out_t held;
            int   irw_cnt;
            int   pcw_cnt;
            held = '0; held.mrd = 1'b1; held.srcb = 2'b01;
            irw_cnt = 0; pcw_cnt = 0;
            // FETCH stalled two cycles, then completes once.
            bus.Opcode = 4'b1000;
            bus.MemReady = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("fetch_wait", act, (c < 2) ? held : fetch_exp());
                irw_cnt += int'(bus.IRWrite);
                pcw_cnt += int'(bus.PCWriteEn);
                @(posedge clk);
                #1;
                if (c == 1) bus.MemReady = 1'b1;
            end
            checks++;
            if (irw_cnt != 1 || pcw_cnt != 1) begin
                errors++;
                $display("FAIL fetch_wait_once: irw %0d pcw %0d expected 1 1", irw_cnt, pcw_cnt);
            end
            for (int c = 1; c < 3; c++) begin
                @(negedge clk);
                chk("jump_after_wait", act, model(4'b1000, 1'b0, c));
                @(posedge clk);
                #1;
            end
            // SW with MWR stalled one cycle: no Retire until ready.
            bus.Opcode = 4'b0101;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("sw_pre", act, model(4'b0101, 1'b0, c));
                @(posedge clk);
                #1;
            end
            bus.MemReady = 1'b0;
            held = '0; held.mwr = 1'b1; held.iord = 1'b1;
            @(negedge clk);
            chk("mwr_wait", act, held);
            @(posedge clk);
            #1;
            bus.MemReady = 1'b1;
            @(negedge clk);
            chk("mwr_done", act, model(4'b0101, 1'b0, 3));
            @(posedge clk);
            #1;
        end
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            logic       z;
            op = 4'($urandom_range(0, 15));
            z  = 1'($urandom_range(0, 1));
            run_instr(op, z, lat_of(op), 1'b1);
        end

        @(negedge clk);
        chk("final_fetch", act, fetch_exp());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
